// File: rtl/magnitude_search_if.sv
// Comparator-side bundle for magnitude_search: start request, comparator flags and result outputs.
// master = search controller, slave = start source / comparator / LED side.
interface magnitude_search_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             a_greater_b;
  logic             a_lesser_b;
  logic             a_equal_b;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] value;
  logic [3:0]       steps;
  logic             error;

  modport master (
    input  start, a_greater_b, a_lesser_b, a_equal_b,
    output probe, busy, done, found, value, steps, error
  );

  modport slave (
    output start, a_greater_b, a_lesser_b, a_equal_b,
    input  probe, busy, done, found, value, steps, error
  );
endinterface

// File: rtl/magnitude_search.sv
// Binary-search controller that recovers a hidden WIDTH-bit operand from gt/lt/eq comparator flags.
// Optional FLAG_CHECK_EN: non-one-hot flags abort the search with error set.
module magnitude_search #(
  parameter int WIDTH           = 4,
  parameter int COMPARE_LATENCY = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  magnitude_search_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_SAMPLE, S_DONE, S_FAIL} state_e;

  localparam logic [WIDTH-1:0] MAXV       = '1;
  localparam int               WCW        = (COMPARE_LATENCY < 1) ? 1 : $clog2(COMPARE_LATENCY + 1);
  localparam logic [3:0]       STEP_LIMIT = 4'(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0] probe_q, probe_d, value_q, value_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [3:0]       steps_q, steps_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   mid_sum;
  logic             busy, done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      probe_q <= '0;
      value_q <= '0;
      wait_q  <= '0;
      steps_q <= '0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      probe_q <= probe_d;
      value_q <= value_d;
      wait_q  <= wait_d;
      steps_q <= steps_d;
      found_q <= found_d;
      err_q   <= err_d;
    end
  end

  // Midpoint at WIDTH+1 bits so lo+hi cannot wrap.
  assign mid_sum = {1'b0, lo_q} + {1'b0, hi_q};

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    probe_d = probe_q;
    value_d = value_q;
    wait_d  = wait_q;
    steps_d = steps_q;
    found_d = found_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          found_d = 1'b0;
          value_d = '0;
          steps_d = '0;
          err_d   = 1'b0;
          lo_d    = '0;
          hi_d    = MAXV;
        end
      end
      S_LOAD: begin
        probe_d = WIDTH'(mid_sum >> 1);
        wait_d  = WCW'(COMPARE_LATENCY);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_SAMPLE;
        else              wait_d  = wait_q - WCW'(1);
      end
      S_SAMPLE: begin
        steps_d = steps_q + 4'd1;
`ifdef FLAG_CHECK_EN
        if (!$onehot({bus.a_greater_b, bus.a_lesser_b, bus.a_equal_b})) begin
          err_d   = 1'b1;
          state_d = S_FAIL;
        end else
`endif
        if (bus.a_equal_b) begin
          value_d = probe_q;
          found_d = 1'b1;
          state_d = S_DONE;
        end else if (bus.a_greater_b) begin
          if (probe_q == MAXV) begin
            state_d = S_FAIL;
          end else begin
            lo_d    = probe_q + WIDTH'(1);
            state_d = (lo_d > hi_q || steps_d == STEP_LIMIT) ? S_FAIL : S_LOAD;
          end
        end else begin
          // lt, or no flag at all, narrows from above
          if (probe_q == '0) begin
            state_d = S_FAIL;
          end else begin
            hi_d    = probe_q - WIDTH'(1);
            state_d = (lo_q > hi_d || steps_d == STEP_LIMIT) ? S_FAIL : S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_LOAD, S_WAIT, S_SAMPLE: busy = 1'b1;
      S_DONE, S_FAIL:           done = 1'b1;
      default: ;
    endcase
  end

  assign bus.probe = probe_q;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.found = found_q;
  assign bus.value = value_q;
  assign bus.steps = steps_q;
`ifdef FLAG_CHECK_EN
  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

endmodule
